// File: rtl/vstructs.sv
// Shared vector-unit types: FP writeback entry layout and the FP ALU exit-port count.
package vstructs;
    localparam int FP_EXIT_PORTS = 4;
    localparam int FP_DATA_W     = 32;
    localparam int FP_TICKET_W   = 5;
    localparam int FP_DST_W      = 5;

    typedef struct packed {
        logic [FP_DATA_W-1:0]   data;
        logic [FP_TICKET_W-1:0] ticket;
        logic [FP_DST_W-1:0]    dst;
    } fp_wb_entry_t;
endpackage

// File: rtl/v_mpush_fifo.sv
// Multi-push, single-pop FIFO: up to NPORTS writes per cycle, compacted into
// consecutive slots in port order; excess writes beyond free space are dropped.
module v_mpush_fifo #(
    parameter int W      = 42,
    parameter int DEPTH  = 8,
    parameter int NPORTS = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic [NPORTS-1:0]            push_vld_i,
    input  logic [NPORTS-1:0][W-1:0]     push_data_i,
    input  logic                         pop_req_i,
    output logic                         head_vld_o,
    output logic [W-1:0]                 head_o,
    output logic [PTR_W:0]               count_o,
    output logic                         drop_o
);
    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          count_q, count_d;
    logic [PTR_W+1:0]        cap, slot;
    logic [PTR_W-1:0]        widx;
    logic                    pop;

    assign head_vld_o = (count_q != '0);
    assign head_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_comb begin
        pop      = head_vld_o & pop_req_i;
        // A pop in this cycle frees its slot for a same-cycle push.
        cap      = (PTR_W+2)'(DEPTH) - {1'b0, count_q} + (PTR_W+2)'(pop);
        slot     = '0;
        widx     = wr_ptr_q;
        drop_o   = 1'b0;
        mem_d    = mem_q;
        for (int i = 0; i < NPORTS; i++) begin
            if (push_vld_i[i]) begin
                if (slot < cap) begin
                    widx = wr_ptr_q + slot[PTR_W-1:0];
                    if (!flush_i) mem_d[widx] = push_data_i[i];
                    slot = slot + 1'b1;
                end else begin
                    drop_o = 1'b1;
                end
            end
        end
        wr_ptr_d = wr_ptr_q + slot[PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + slot[PTR_W:0] - (PTR_W+1)'(pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/v_fp_wb_collector.sv
// Collects FP ALU completions from EX1..EX4 into a multi-push FIFO and serves
// them one per cycle to the vector writeback port.
module v_fp_wb_collector
    import vstructs::*;
#(
    parameter int DATA_WIDTH  = FP_DATA_W,
    parameter int TICKET_BITS = FP_TICKET_W,
    parameter int DST_BITS    = FP_DST_W,
    parameter int DEPTH       = 8,
    parameter int PTR_W       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   ready_res_ex1_i,
    input  logic                   ready_res_ex2_i,
    input  logic                   ready_res_ex3_i,
    input  logic                   ready_res_ex4_i,
    input  logic [DATA_WIDTH-1:0]  result_ex1_i,
    input  logic [DATA_WIDTH-1:0]  result_ex2_i,
    input  logic [DATA_WIDTH-1:0]  result_ex3_i,
    input  logic [DATA_WIDTH-1:0]  result_ex4_i,
    input  logic [TICKET_BITS-1:0] ticket_ex1_i,
    input  logic [TICKET_BITS-1:0] ticket_ex2_i,
    input  logic [TICKET_BITS-1:0] ticket_ex3_i,
    input  logic [TICKET_BITS-1:0] ticket_ex4_i,
    input  logic [DST_BITS-1:0]    dst_ex1_i,
    input  logic [DST_BITS-1:0]    dst_ex2_i,
    input  logic [DST_BITS-1:0]    dst_ex3_i,
    input  logic [DST_BITS-1:0]    dst_ex4_i,
    output logic                   stall_o,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [DATA_WIDTH-1:0]  wb_data_o,
    output logic [TICKET_BITS-1:0] wb_ticket_o,
    output logic [DST_BITS-1:0]    wb_dst_o,
    output logic [PTR_W:0]         count_o,
    output logic                   overflow_o
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [TICKET_BITS-1:0] ticket;
        logic [DST_BITS-1:0]    dst;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [FP_EXIT_PORTS-1:0]         push_vld;
    logic [FP_EXIT_PORTS-1:0][EW-1:0] push_data;
    entry_t                           head;
    logic                             drop;
    logic                             overflow_q, overflow_d;

    // Port 0 is filled first: the oldest stage (EX4) leads.
    assign push_vld     = {ready_res_ex1_i, ready_res_ex2_i, ready_res_ex3_i, ready_res_ex4_i};
    assign push_data[0] = {result_ex4_i, ticket_ex4_i, dst_ex4_i};
    assign push_data[1] = {result_ex3_i, ticket_ex3_i, dst_ex3_i};
    assign push_data[2] = {result_ex2_i, ticket_ex2_i, dst_ex2_i};
    assign push_data[3] = {result_ex1_i, ticket_ex1_i, dst_ex1_i};

    v_mpush_fifo #(
        .W      (EW),
        .DEPTH  (DEPTH),
        .NPORTS (FP_EXIT_PORTS),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .push_vld_i  (push_vld),
        .push_data_i (push_data),
        .pop_req_i   (wb_ready_i),
        .head_vld_o  (wb_valid_o),
        .head_o      (head),
        .count_o     (count_o),
        .drop_o      (drop)
    );

    assign wb_data_o   = head.data;
    assign wb_ticket_o = head.ticket;
    assign wb_dst_o    = head.dst;

    // Registered count only: leaves room for the 3 ops still in flight after stall.
    assign stall_o = (count_o > (PTR_W+1)'(DEPTH - FP_EXIT_PORTS));

    always_comb begin
        overflow_d = overflow_q | (drop & ~flush_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_v_fp_wb_collector.sv
// Directed bench for v_fp_wb_collector with a queue scoreboard of expected writebacks.
module tb_v_fp_wb_collector;
    localparam int DEPTH = 8;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, wb_ready = 1'b0;
    logic [3:0]  rdy = '0;
    logic [31:0] dat [4];
    logic [4:0]  tk [4];
    logic [4:0]  ds [4];
    logic        stall, wb_valid, overflow;
    logic [31:0] wb_data;
    logic [4:0]  wb_ticket, wb_dst;
    logic [3:0]  count;

    typedef struct { logic [31:0] d; logic [4:0] t; logic [4:0] s; } ent_t;
    ent_t q[$];
    int   mc = 0;
    bit   movf = 0;
    int   passes = 0, fails = 0, checks = 0;

    always #5 clk = ~clk;

    v_fp_wb_collector dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .ready_res_ex1_i(rdy[0]), .ready_res_ex2_i(rdy[1]),
        .ready_res_ex3_i(rdy[2]), .ready_res_ex4_i(rdy[3]),
        .result_ex1_i(dat[0]), .result_ex2_i(dat[1]),
        .result_ex3_i(dat[2]), .result_ex4_i(dat[3]),
        .ticket_ex1_i(tk[0]), .ticket_ex2_i(tk[1]),
        .ticket_ex3_i(tk[2]), .ticket_ex4_i(tk[3]),
        .dst_ex1_i(ds[0]), .dst_ex2_i(ds[1]), .dst_ex3_i(ds[2]), .dst_ex4_i(ds[3]),
        .stall_o(stall), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
        .wb_data_o(wb_data), .wb_ticket_o(wb_ticket), .wb_dst_o(wb_dst),
        .count_o(count), .overflow_o(overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_stage(input int n, input logic [31:0] d, input logic [4:0] t, input logic [4:0] s);
        rdy[n-1] = 1'b1;
        dat[n-1] = d;
        tk[n-1]  = t;
        ds[n-1]  = s;
    endtask

    // One clock: check state at negedge, advance model, return #1 after posedge.
    task automatic tick();
        ent_t e;
        int   cap;
        bit   pop;
        @(negedge clk);
        chk("count", 64'(count), 64'(mc));
        chk("valid", 64'(wb_valid), 64'(mc != 0));
        chk("stall", 64'(stall), 64'((DEPTH - mc) < 4));
        chk("overflow", 64'(overflow), 64'(movf));
        if (mc != 0) begin
            e = q[0];
            chk("wb_data", 64'(wb_data), 64'(e.d));
            chk("wb_ticket", 64'(wb_ticket), 64'(e.t));
            chk("wb_dst", 64'(wb_dst), 64'(e.s));
        end
        pop = (mc != 0) && wb_ready;
        if (pop) begin
            void'(q.pop_front());
            mc--;
        end
        cap = DEPTH - mc;
        if (flush) begin
            q.delete();
            mc = 0;
        end else begin
            for (int n = 3; n >= 0; n--) begin
                if (rdy[n]) begin
                    if (cap > 0) begin
                        e.d = dat[n]; e.t = tk[n]; e.s = ds[n];
                        q.push_back(e);
                        mc++;
                        cap--;
                    end else begin
                        movf = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rdy = '0;
        wb_ready = 1'b1;
        repeat (DEPTH + 4) tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin dat[i] = '0; tk[i] = '0; ds[i] = '0; end
        #2;
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single push from EX2
        wb_ready = 1'b1;
        set_stage(2, 32'h3F80_0000, 5'd3, 5'd7);
        tick();
        rdy = '0;
        tick();
        tick();

        // Quad push: head order EX4, EX3, EX2, EX1
        for (int n = 1; n <= 4; n++) set_stage(n, 32'(n), 5'(n + 8), 5'(n + 16));
        tick();
        rdy = '0;
        repeat (5) tick();

        // Back-pressure fill to full
        wb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy = '0;
            set_stage(1 + (i % 4), 32'hA000 + 32'(i), 5'(i), 5'(31 - i));
            tick();
        end
        rdy = '0;
        repeat (2) tick();

        // Full with pop: one push accepted, then two pushes drop the EX1 entry
        wb_ready = 1'b1;
        set_stage(3, 32'hB0B0, 5'd1, 5'd2);
        tick();
        rdy = '0;
        set_stage(1, 32'hC001, 5'd4, 5'd5);
        set_stage(2, 32'hC002, 5'd6, 5'd8);
        tick();
        drain();

        // Wrap: 13 entries through, one per cycle
        for (int i = 0; i < 13; i++) begin
            rdy = '0;
            set_stage(4, 32'hD000 + 32'(i), 5'(i), 5'(i + 3));
            tick();
        end
        drain();

        // Flush with a simultaneous push
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rdy = '0;
            set_stage(2, 32'hE000 + 32'(i), 5'(i), 5'(i));
            tick();
        end
        rdy = '0;
        set_stage(1, 32'hEEEE, 5'd9, 5'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rdy = '0;
        tick();

        // Async reset mid-stream
        for (int i = 0; i < 6; i++) begin
            rdy = '0;
            set_stage(3, 32'hF000 + 32'(i), 5'(i), 5'(i));
            tick();
        end
        rdy = '0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(wb_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_stall", 64'(stall), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        q.delete();
        mc = 0;
        movf = 0;
        #1;
        rst_n = 1'b1;
        wb_ready = 1'b1;
        set_stage(4, 32'h1234_5678, 5'd30, 5'd31);
        tick();
        rdy = '0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
